// File: rtl/grf_wb_arbiter_pkg.sv
// grf_wb_arbiter_pkg: shared widths, register-zero constant, write-request struct and grant encoding
package grf_wb_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef struct packed {
    reg_addr_t waddr;
    data_t     wdata;
    data_t     pc;
  } wb_req_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_A, GNT_B} gnt_t;
endpackage

// File: rtl/grf_wb_arbiter_if.sv
// grf_wb_arbiter_if: A writeback, B handshake, decode RAW query and GRF write buses; master drives requests, slave is the arbiter
interface grf_wb_arbiter_if #(parameter int FIFO_DEPTH = 2);
  import grf_wb_arbiter_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic           a_we;
  reg_addr_t      a_waddr;
  data_t          a_wdata;
  data_t          a_pc;
  logic           stall_a;
  logic           b_valid;
  reg_addr_t      b_waddr;
  data_t          b_wdata;
  data_t          b_pc;
  logic           b_ready;
  reg_addr_t      rd_addr0;
  reg_addr_t      rd_addr1;
  logic           rd_pend0;
  logic           rd_pend1;
  logic           grf_we;
  reg_addr_t      grf_waddr;
  data_t          grf_wdata;
  data_t          grf_wpc;
  logic [CW-1:0]  fifo_count;
  modport master (
    output a_we, a_waddr, a_wdata, a_pc, b_valid, b_waddr, b_wdata, b_pc, rd_addr0, rd_addr1,
    input  stall_a, b_ready, rd_pend0, rd_pend1, grf_we, grf_waddr, grf_wdata, grf_wpc, fifo_count
  );
  modport slave (
    input  a_we, a_waddr, a_wdata, a_pc, b_valid, b_waddr, b_wdata, b_pc, rd_addr0, rd_addr1,
    output stall_a, b_ready, rd_pend0, rd_pend1, grf_we, grf_waddr, grf_wdata, grf_wpc, fifo_count
  );
endinterface

// File: rtl/grf_wb_fifo.sv
// grf_wb_fifo: circular B-result buffer with per-entry valid, address kill, two CAM ports, head/count outputs
module grf_wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  wb_req_t                push_req,
  input  logic                   push_kill,
  input  logic                   pop,
  input  logic                   kill,
  input  reg_addr_t              kill_addr,
  input  reg_addr_t              cam_addr0,
  input  reg_addr_t              cam_addr1,
  output logic                   cam_hit0,
  output logic                   cam_hit1,
  output logic                   head_live,
  output logic                   head_dead,
  output wb_req_t                head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++)
      if (kill && mem_q[i].waddr == kill_addr) vld_d[i] = 1'b0;
    if (pop) vld_d[rd_q] = 1'b0;
    if (push) begin
      mem_d[wr_q] = push_req;
      vld_d[wr_q] = !push_kill;
    end
    rd_d  = pop ? rd_q + PW'(1) : rd_q;
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_comb begin
    cam_hit0 = 1'b0;
    cam_hit1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cam_hit0 = cam_hit0 | (vld_q[i] && mem_q[i].waddr == cam_addr0);
      cam_hit1 = cam_hit1 | (vld_q[i] && mem_q[i].waddr == cam_addr1);
    end
  end
  // A valid bit is only ever set on an occupied slot, so it alone marks a live head
  assign head_live = vld_q[rd_q];
  assign head_dead = cnt_q != '0 && !vld_q[rd_q];
  assign head      = mem_q[rd_q];
  assign count     = cnt_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: GRF write-port arbiter between in-order writeback A and buffered long-latency results B
// ports: clk, reset (sync, active-low), bus (slave modport: A/B requests, stall_a, b_ready, RAW pend, GRF write, fifo_count)
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  grf_wb_arbiter_if.slave     bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);
  logic [AW-1:0] age_q, age_d;
  logic [CW-1:0] count;
  logic          head_live, head_dead, hit0, hit1, a_eff, hs, push, push_kill, pop, kill;
  wb_req_t       head, push_req;
  gnt_t          gnt;
  always_comb begin
    a_eff        = bus.a_we && bus.a_waddr != REG_ZERO;
    // b_ready looks only at the registered count: a same-cycle pop never frees a slot
    bus.b_ready  = reset && count < CW'(FIFO_DEPTH);
    bus.stall_a  = reset && head_live && age_q == AW'(STARVE_LIMIT);
    gnt          = !reset ? GNT_NONE : bus.stall_a ? GNT_B : a_eff ? GNT_A : head_live ? GNT_B : GNT_NONE;
    hs           = bus.b_valid && bus.b_ready;
    push         = hs && bus.b_waddr != REG_ZERO;
    push_req     = '{waddr: bus.b_waddr, wdata: bus.b_wdata, pc: bus.b_pc};
    kill         = gnt == GNT_A;
    // A is younger than anything in B, so a same-address B arriving this cycle is already stale
    push_kill    = kill && bus.b_waddr == bus.a_waddr;
    pop          = gnt == GNT_B || head_dead;
    age_d        = (head_live && gnt != GNT_B) ? age_q + AW'(1) : '0;
    bus.grf_we    = gnt != GNT_NONE;
    bus.grf_waddr = gnt == GNT_A ? bus.a_waddr : gnt == GNT_B ? head.waddr : REG_ZERO;
    bus.grf_wdata = gnt == GNT_A ? bus.a_wdata : gnt == GNT_B ? head.wdata : '0;
    bus.grf_wpc   = gnt == GNT_A ? bus.a_pc : gnt == GNT_B ? head.pc : '0;
    bus.rd_pend0  = reset && bus.rd_addr0 != REG_ZERO && (hit0 || (hs && bus.b_waddr == bus.rd_addr0));
    bus.rd_pend1  = reset && bus.rd_addr1 != REG_ZERO && (hit1 || (hs && bus.b_waddr == bus.rd_addr1));
    bus.fifo_count = count;
  end
  always_ff @(posedge clk) age_q <= !reset ? '0 : age_d;
  grf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_req  (push_req),
    .push_kill (push_kill),
    .pop       (pop),
    .kill      (kill),
    .kill_addr (bus.a_waddr),
    .cam_addr0 (bus.rd_addr0),
    .cam_addr1 (bus.rd_addr1),
    .cam_hit0  (hit0),
    .cam_hit1  (hit1),
    .head_live (head_live),
    .head_dead (head_dead),
    .head      (head),
    .count     (count)
  );
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: queue-based reference model checked every cycle, directed scenarios with literal expectations, then random traffic
module tb_grf_wb_arbiter;
  localparam int D = 2;
  localparam int L = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  grf_wb_arbiter_if #(.FIFO_DEPTH(D)) bus();
  grf_wb_arbiter #(.FIFO_DEPTH(D), .STARVE_LIMIT(L)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    bit          live;
  } ent_t;
  ent_t q[$];
  int age = 0;
  int checks = 0;
  int failures = 0;
  logic c_we, c_stall, c_ready, c_p0, c_p1;
  logic [4:0] c_wa;
  logic [31:0] c_wd, c_pc;
  int c_cnt;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit live_match(logic [4:0] a);
    foreach (q[i]) if (q[i].live && q[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction
  task automatic idle();
    bus.a_we = 0; bus.a_waddr = 0; bus.a_wdata = 0; bus.a_pc = 0;
    bus.b_valid = 0; bus.b_waddr = 0; bus.b_wdata = 0; bus.b_pc = 0;
    bus.rd_addr0 = 0; bus.rd_addr1 = 0;
  endtask
  // One clock: compare DUT outputs against the model at negedge, then advance the model across the posedge
  task automatic cyc();
    int cnt;
    bit hl, ae, rdy, stall, ag, bg, hs, pop, ewe, p0, p1;
    logic [4:0] ewa;
    logic [31:0] ewd, epc;
    ent_t e;
    @(negedge clk);
    cnt   = q.size();
    hl    = cnt > 0 && q[0].live;
    ae    = bus.a_we && bus.a_waddr != 0;
    rdy   = reset && cnt < D;
    stall = reset && hl && age == L;
    bg    = reset && (stall || (!ae && hl));
    ag    = reset && !stall && ae;
    hs    = bus.b_valid && rdy;
    p0    = reset && bus.rd_addr0 != 0 && (live_match(bus.rd_addr0) || (hs && bus.b_waddr == bus.rd_addr0));
    p1    = reset && bus.rd_addr1 != 0 && (live_match(bus.rd_addr1) || (hs && bus.b_waddr == bus.rd_addr1));
    ewe   = ag || bg;
    ewa   = ag ? bus.a_waddr : bg ? q[0].addr : 5'd0;
    ewd   = ag ? bus.a_wdata : bg ? q[0].data : 32'd0;
    epc   = ag ? bus.a_pc : bg ? q[0].pc : 32'd0;
    chk("b_ready", bus.b_ready, rdy);
    chk("stall_a", bus.stall_a, stall);
    chk("grf_we", bus.grf_we, ewe);
    chk("grf_waddr", bus.grf_waddr, ewa);
    chk("grf_wdata", bus.grf_wdata, ewd);
    chk("grf_wpc", bus.grf_wpc, epc);
    chk("rd_pend0", bus.rd_pend0, p0);
    chk("rd_pend1", bus.rd_pend1, p1);
    chk("fifo_count", bus.fifo_count, cnt);
    c_we = bus.grf_we; c_stall = bus.stall_a; c_ready = bus.b_ready;
    c_p0 = bus.rd_pend0; c_p1 = bus.rd_pend1; c_wa = bus.grf_waddr;
    c_wd = bus.grf_wdata; c_pc = bus.grf_wpc; c_cnt = int'(bus.fifo_count);
    if (!reset) begin
      q.delete();
      age = 0;
    end else begin
      pop = bg || (cnt > 0 && !q[0].live);
      age = (hl && !bg) ? age + 1 : 0;
      if (ag) foreach (q[i]) if (q[i].addr == bus.a_waddr) q[i].live = 1'b0;
      if (pop) void'(q.pop_front());
      if (hs && bus.b_waddr != 0) begin
        e.addr = bus.b_waddr; e.data = bus.b_wdata; e.pc = bus.b_pc;
        e.live = !(ag && bus.b_waddr == bus.a_waddr);
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic a_req(logic [4:0] a, logic [31:0] d);
    bus.a_we = 1; bus.a_waddr = a; bus.a_wdata = d; bus.a_pc = 32'h1000 + d;
  endtask
  task automatic b_req(logic [4:0] a, logic [31:0] d);
    bus.b_valid = 1; bus.b_waddr = a; bus.b_wdata = d; bus.b_pc = 32'h2000 + d;
  endtask
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    cyc();
    chk("rst_ready_low", c_ready, 0);
    chk("rst_we_low", c_we, 0);
    reset = 1;
    cyc();
    chk("rst_cnt", c_cnt, 0);
    chk("rst_ready_high", c_ready, 1);
    // B only: write one cycle after handshake, pending via bypass then entry
    b_req(8, 32'h1234); bus.rd_addr0 = 8;
    cyc();
    chk("bonly_pend_t", c_p0, 1);
    chk("bonly_we_t", c_we, 0);
    bus.b_valid = 0;
    cyc();
    chk("bonly_we", c_we, 1);
    chk("bonly_wa", c_wa, 8);
    chk("bonly_wd", c_wd, 32'h1234);
    chk("bonly_pc", c_pc, 32'h3234);
    chk("bonly_pend_t1", c_p0, 1);
    cyc();
    chk("bonly_pend_t2", c_p0, 0);
    // starvation: $9 waits behind continuous A writes to $3
    idle(); a_req(3, 32'h33); b_req(9, 32'h99);
    cyc();
    bus.b_valid = 0;
    for (int i = 0; i < L; i++) begin
      cyc();
      chk("starve_wait_stall", c_stall, 0);
      chk("starve_wait_wa", c_wa, 3);
    end
    cyc();
    chk("starve_stall", c_stall, 1);
    chk("starve_wa", c_wa, 9);
    chk("starve_wd", c_wd, 32'h99);
    cyc();
    chk("starve_release", c_stall, 0);
    chk("starve_a_again", c_wa, 3);
    // WAW kill: A to $5 kills queued $5 which then pops silently
    idle(); b_req(5, 32'h5555);
    cyc();
    idle(); a_req(5, 32'hAAAA);
    cyc();
    chk("waw_wa", c_wa, 5);
    chk("waw_wd", c_wd, 32'hAAAA);
    chk("waw_cnt", c_cnt, 1);
    idle();
    cyc();
    chk("waw_silent", c_we, 0);
    chk("waw_cnt_dead", c_cnt, 1);
    cyc();
    chk("waw_cnt_zero", c_cnt, 0);
    // full plus pop: third item waits for a slot, all drain in order
    a_req(3, 32'h3); b_req(10, 32'h10);
    cyc();
    b_req(11, 32'h11);
    cyc();
    bus.a_we = 0; b_req(12, 32'h12);
    cyc();
    chk("full_ready", c_ready, 0);
    chk("full_cnt", c_cnt, 2);
    chk("full_wa0", c_wa, 10);
    cyc();
    chk("full_ready1", c_ready, 1);
    chk("full_wa1", c_wa, 11);
    bus.b_valid = 0;
    cyc();
    chk("full_wa2", c_wa, 12);
    chk("full_cnt2", c_cnt, 1);
    cyc();
    chk("full_empty", c_cnt, 0);
    // $0 on both ports
    idle(); a_req(0, 32'h77); b_req(0, 32'h66);
    cyc();
    chk("zero_we", c_we, 0);
    chk("zero_p0", c_p0, 0);
    chk("zero_p1", c_p1, 0);
    idle();
    cyc();
    chk("zero_cnt", c_cnt, 0);
    // reset mid-operation with two entries queued
    a_req(3, 32'h3); b_req(20, 32'h20);
    cyc();
    b_req(21, 32'h21);
    cyc();
    idle(); reset = 0;
    cyc();
    chk("mid_rst_we", c_we, 0);
    chk("mid_rst_ready", c_ready, 0);
    chk("mid_rst_cnt", c_cnt, 2);
    reset = 1;
    cyc();
    chk("mid_rst_cnt0", c_cnt, 0);
    chk("mid_rst_ready1", c_ready, 1);
    chk("mid_rst_we1", c_we, 0);
    // random traffic over a small address range to provoke WAW, RAW and starvation
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 99) != 0);
      bus.a_we = ($urandom_range(0, 9) < 6);
      bus.a_waddr = 5'($urandom_range(0, 7));
      bus.a_wdata = $urandom;
      bus.a_pc = $urandom;
      bus.b_valid = $urandom_range(0, 1) == 1;
      bus.b_waddr = 5'($urandom_range(0, 7));
      bus.b_wdata = $urandom;
      bus.b_pc = $urandom;
      bus.rd_addr0 = 5'($urandom_range(0, 7));
      bus.rd_addr1 = 5'($urandom_range(0, 7));
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
